// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer: registers the address-phase slave select into the
// data phase, muxes slave responses and answers unmapped selects with a two-cycle ERROR.
module ahb_resp_mux #(
   parameter int NUM_SLAVES   = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int SEL_WIDTH    = 3,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                             hclk,
   input  logic                             hreset,
   input  logic [SEL_WIDTH-1:0]             sel,
   input  logic [1:0]                       htrans,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
   input  logic [NUM_SLAVES-1:0]            hreadyout_s,
   input  logic [NUM_SLAVES-1:0]            hresp_s,
   output logic [DATA_WIDTH-1:0]            hrdata,
   output logic                             hready,
   output logic                             hresp,
   output logic [ERRCNT_WIDTH-1:0]          err_count
);

   typedef enum logic [1:0] {
      DP_IDLE,
      DP_SLAVE,
      DP_ERR1,
      DP_ERR2
   } dp_state_t;

   // One extra bit so the bound still fits when every select value is mapped.
   localparam logic [SEL_WIDTH:0] NUM_SLAVES_W = (SEL_WIDTH + 1)'(NUM_SLAVES);

   dp_state_t                 dp_state;
   dp_state_t                 dp_state_next;
   logic [SEL_WIDTH-1:0]      ds_sel;
   logic [SEL_WIDTH-1:0]      ds_sel_next;
   logic [DATA_WIDTH-1:0]     slave_data [NUM_SLAVES];
   logic [DATA_WIDTH-1:0]     mux_data;
   logic                      mux_ready;
   logic                      mux_resp;
   logic                      sel_mapped;
   logic                      unused_ok;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 2 ** SEL_WIDTH) begin : g_bad_param
      $error("ahb_resp_mux: NUM_SLAVES must be in 1..2**SEL_WIDTH");
   end

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slice
      assign slave_data[gi] = hrdata_s[gi*DATA_WIDTH +: DATA_WIDTH];
   end

   assign sel_mapped = ({1'b0, sel} < NUM_SLAVES_W);
   assign unused_ok  = &{1'b0, htrans[0]};

   always_comb begin
      mux_data  = '0;
      mux_ready = 1'b1;
      mux_resp  = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
         if (ds_sel == SEL_WIDTH'(k)) begin
            mux_data  = slave_data[k];
            mux_ready = hreadyout_s[k];
            mux_resp  = hresp_s[k];
         end
      end
   end

   always_comb begin
      hrdata = '0;
      hready = 1'b1;
      hresp  = 1'b0;
      case (dp_state)
         DP_IDLE: begin
            hready = 1'b1;
         end
         DP_SLAVE: begin
            hrdata = mux_data;
            hready = mux_ready;
            hresp  = mux_resp;
         end
         DP_ERR1: begin
            hready = 1'b0;
            hresp  = 1'b1;
         end
         DP_ERR2: begin
            hready = 1'b1;
            hresp  = 1'b1;
         end
         default: begin
            hready = 1'b1;
         end
      endcase
   end

   // ERR1 always advances; otherwise a new address phase is taken only when hready is high.
   always_comb begin
      dp_state_next = dp_state;
      ds_sel_next   = ds_sel;
      if (dp_state == DP_ERR1) begin
         dp_state_next = DP_ERR2;
      end else if (hready) begin
         if (!htrans[1]) begin
            dp_state_next = DP_IDLE;
         end else if (sel_mapped) begin
            dp_state_next = DP_SLAVE;
            ds_sel_next   = sel;
         end else begin
            dp_state_next = DP_ERR1;
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         dp_state <= DP_IDLE;
         ds_sel   <= '0;
      end else begin
         dp_state <= dp_state_next;
         ds_sel   <= ds_sel_next;
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         err_count <= '0;
      end else if (hready && hresp && (err_count != {ERRCNT_WIDTH{1'b1}})) begin
         err_count <= err_count + ERRCNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Bench for ahb_resp_mux: directed vector table, async reset during ERR1, then random
// traffic against a transfer-level reference model (a second instance checks saturation).
module tb_ahb_resp_mux;

   logic         hclk;
   logic         hreset;
   logic [2:0]   sel;
   logic [1:0]   htrans;
   logic [127:0] hrdata_s;
   logic [3:0]   hreadyout_s;
   logic [3:0]   hresp_s;
   logic [31:0]  hrdata;
   logic         hready;
   logic         hresp;
   logic [7:0]   err_count;
   logic [31:0]  hrdata_b;
   logic         hready_b;
   logic         hresp_b;
   logic [1:0]   err_count_b;

   int vectors;
   int miscompares;

   ahb_resp_mux #(.NUM_SLAVES(4), .DATA_WIDTH(32), .SEL_WIDTH(3), .ERRCNT_WIDTH(8)) dut (
      .hclk(hclk), .hreset(hreset), .sel(sel), .htrans(htrans), .hrdata_s(hrdata_s),
      .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata(hrdata), .hready(hready),
      .hresp(hresp), .err_count(err_count)
   );

   ahb_resp_mux #(.NUM_SLAVES(4), .DATA_WIDTH(32), .SEL_WIDTH(3), .ERRCNT_WIDTH(2)) dut_sat (
      .hclk(hclk), .hreset(hreset), .sel(sel), .htrans(htrans), .hrdata_s(hrdata_s),
      .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata(hrdata_b), .hready(hready_b),
      .hresp(hresp_b), .err_count(err_count_b)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   typedef struct {
      logic [1:0]  htrans;
      logic [2:0]  sel;
      logic [3:0]  rdy;
      logic [3:0]  resp;
      logic [31:0] exp_data;
      logic        exp_ready;
      logic        exp_resp;
      int          exp_cnt;
   } vec_t;

   localparam int NVEC = 29;
   vec_t tbl [NVEC];

   function automatic vec_t mk(logic [1:0] t, logic [2:0] s, logic [3:0] r, logic [3:0] e,
                               logic [31:0] d, logic rd, logic rs, int c);
      vec_t v;
      v.htrans = t; v.sel = s; v.rdy = r; v.resp = e;
      v.exp_data = d; v.exp_ready = rd; v.exp_resp = rs; v.exp_cnt = c;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic check_all(input string tag, input logic [31:0] d, input logic rd,
                            input logic rs, input int cnt);
      chk({tag, ".hrdata"}, hrdata, d);
      chk({tag, ".hready"}, 32'(hready), 32'(rd));
      chk({tag, ".hresp"}, 32'(hresp), 32'(rs));
      chk({tag, ".err_count"}, 32'(err_count), 32'(sat(cnt, 255)));
      chk({tag, ".hready_b"}, 32'(hready_b), 32'(rd));
      chk({tag, ".err_count_b"}, 32'(err_count_b), 32'(sat(cnt, 3)));
   endtask

   // Reference model: the transfer currently in its data phase.
   typedef enum {M_NONE, M_SLAVE, M_UNMAPPED} kind_t;
   kind_t       m_kind;
   int          m_slave;
   int          m_age;
   int          m_errs;
   logic [31:0] e_data;
   logic        e_ready;
   logic        e_resp;

   task automatic model_outputs();
      e_data = 32'h0; e_ready = 1'b1; e_resp = 1'b0;
      if (m_kind == M_SLAVE) begin
         e_data  = hrdata_s[m_slave*32 +: 32];
         e_ready = hreadyout_s[m_slave];
         e_resp  = hresp_s[m_slave];
      end else if (m_kind == M_UNMAPPED) begin
         e_ready = (m_age > 0);
         e_resp  = 1'b1;
      end
   endtask

   task automatic model_edge();
      model_outputs();
      if (e_ready) begin
         if (e_resp) m_errs++;
         m_age = 0;
         if (!htrans[1])          m_kind = M_NONE;
         else if (int'(sel) < 4) begin m_kind = M_SLAVE; m_slave = int'(sel); end
         else                     m_kind = M_UNMAPPED;
      end else begin
         m_age++;
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      hreset = 1'b1;
      htrans = 2'b00; sel = 3'd0;
      hreadyout_s = 4'hF; hresp_s = 4'h0;
      hrdata_s = {32'h3333_0003, 32'hBBBB_0002, 32'hAAAA_0001, 32'h1111_0000};

      //                htrans sel  rdy      resp     data           rdy  resp cnt
      tbl[0]  = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 0);
      tbl[1]  = mk(2'b00, 3'd2, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 0);
      tbl[2]  = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 0);
      tbl[3]  = mk(2'b10, 3'd1, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 0);
      tbl[4]  = mk(2'b10, 3'd2, 4'b1111, 4'b0000, 32'hAAAA_0001, 1'b1, 1'b0, 0);
      tbl[5]  = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'hBBBB_0002, 1'b1, 1'b0, 0);
      tbl[6]  = mk(2'b10, 3'd3, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 0);
      tbl[7]  = mk(2'b10, 3'd0, 4'b0111, 4'b0000, 32'h3333_0003, 1'b0, 1'b0, 0);
      tbl[8]  = mk(2'b10, 3'd0, 4'b0111, 4'b0000, 32'h3333_0003, 1'b0, 1'b0, 0);
      tbl[9]  = mk(2'b10, 3'd5, 4'b1111, 4'b0000, 32'h3333_0003, 1'b1, 1'b0, 0);
      tbl[10] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 0);
      tbl[11] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 0);
      tbl[12] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 1);
      tbl[13] = mk(2'b10, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 1);
      tbl[14] = mk(2'b00, 3'd0, 4'b1110, 4'b0001, 32'h1111_0000, 1'b0, 1'b1, 1);
      tbl[15] = mk(2'b00, 3'd0, 4'b1111, 4'b0001, 32'h1111_0000, 1'b1, 1'b1, 1);
      tbl[16] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2);
      tbl[17] = mk(2'b10, 3'd7, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 2);
      tbl[18] = mk(2'b10, 3'd4, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 2);
      tbl[19] = mk(2'b10, 3'd4, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 2);
      tbl[20] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 3);
      tbl[21] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 3);
      tbl[22] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 4);
      tbl[23] = mk(2'b01, 3'd1, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 4);
      tbl[24] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 4);
      tbl[25] = mk(2'b10, 3'd6, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 4);
      tbl[26] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b0, 1'b1, 4);
      tbl[27] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b1, 4);
      tbl[28] = mk(2'b00, 3'd0, 4'b1111, 4'b0000, 32'h0,         1'b1, 1'b0, 5);

      // Outputs while reset is held.
      #12;
      check_all("in_reset", 32'h0, 1'b1, 1'b0, 0);
      @(posedge hclk); #1;
      hreset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         htrans = tbl[i].htrans; sel = tbl[i].sel;
         hreadyout_s = tbl[i].rdy; hresp_s = tbl[i].resp;
         @(negedge hclk);
         $display("vec %0d: htrans=%b sel=%0d hrdata=%h hready=%b hresp=%b err_count=%0d",
                   i, htrans, sel, hrdata, hready, hresp, err_count);
         check_all($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_ready,
                   tbl[i].exp_resp, tbl[i].exp_cnt);
         @(posedge hclk); #1;
      end

      // Async reset asserted mid-ERR1: response aborted, nothing counted.
      htrans = 2'b10; sel = 3'd5; hreadyout_s = 4'hF; hresp_s = 4'h0;
      @(posedge hclk); #1;
      htrans = 2'b00; sel = 3'd0;
      #1;
      chk("err1.hready", 32'(hready), 32'(1'b0));
      chk("err1.hresp", 32'(hresp), 32'(1'b1));
      hreset = 1'b1;
      #1;
      $display("reset in ERR1: hready=%b hresp=%b err_count=%0d", hready, hresp, err_count);
      check_all("rst_err1", 32'h0, 1'b1, 1'b0, 0);
      @(posedge hclk); #1;
      hreset = 1'b0;
      @(negedge hclk);
      check_all("post_rst", 32'h0, 1'b1, 1'b0, 0);
      @(posedge hclk); #1;

      // Randomized traffic against the transfer-level model.
      m_kind = M_NONE; m_slave = 0; m_age = 0; m_errs = 0;
      for (int i = 0; i < 400; i++) begin
         htrans = 2'($urandom_range(0, 3));
         sel    = 3'($urandom_range(0, 7));
         hrdata_s = {$urandom, $urandom, $urandom, $urandom};
         for (int k = 0; k < 4; k++) begin
            hreadyout_s[k] = ($urandom_range(0, 3) != 0);
            hresp_s[k]     = ($urandom_range(0, 4) == 0);
         end
         @(negedge hclk);
         model_outputs();
         $display("rnd %0d: htrans=%b sel=%0d hrdata=%h hready=%b hresp=%b err_count=%0d",
                  i, htrans, sel, hrdata, hready, hresp, err_count);
         check_all($sformatf("rnd%0d", i), e_data, e_ready, e_resp, m_errs);
         @(posedge hclk);
         model_edge();
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- Parametrised AHB-Lite slave-to-master response multiplexer. Successor to the fixed 4-way combinational read-data mux.
- Registers the address-phase slave select into the data phase, so response muxing is aligned with AHB pipelining.
- Muxes hrdata, hreadyout and hresp from NUM_SLAVES slaves.
- Contains a built-in default slave that issues the two-cycle AHB ERROR response for unmapped selects, plus a saturating error counter. Sits between the address decoder and the master.

Parameters:
- NUM_SLAVES, 4, number of slave response channels (1..(2**SEL_WIDTH)).
- DATA_WIDTH, 32, hrdata width in bits.
- SEL_WIDTH, 3, width of decoder select; values >= NUM_SLAVES are unmapped.
- ERRCNT_WIDTH, 8, width of error counter.

Ports:
- hclk  input  1  bus clock, all state on rising edge.
- hreset  input  1  asynchronous, active-high reset.
- sel  input  SEL_WIDTH  decoder slave index for current address phase.
- htrans  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- hrdata_s  input  NUM_SLAVES*DATA_WIDTH  slave read data, slave k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- hreadyout_s  input  NUM_SLAVES  per-slave hreadyout.
- hresp_s  input  NUM_SLAVES  per-slave hresp (1 = ERROR).
- hrdata  output  DATA_WIDTH  muxed read data to master.
- hready  output  1  muxed hready to master and slaves.
- hresp  output  1  muxed response to master.
- err_count  output  ERRCNT_WIDTH  saturating count of completed ERROR responses.

Behaviour:
- Data-phase state register `dp_state` has four states:
  - DP_IDLE: hrdata=0, hready=1, hresp=0.
  - DP_SLAVE: hrdata=hrdata_s[ds_sel], hready=hreadyout_s[ds_sel], hresp=hresp_s[ds_sel].
  - DP_ERR1: hrdata=0, hready=0, hresp=1.
  - DP_ERR2: hrdata=0, hready=1, hresp=1.
- All outputs are combinational from dp_state/ds_sel and the slave inputs. There is no added latency beyond the AHB address-to-data pipeline.
- Address sampling happens only when hready (output) == 1. On that edge:
  - htrans[1]==0 (IDLE/BUSY) -> DP_IDLE.
  - htrans[1]==1 and sel < NUM_SLAVES -> DP_SLAVE, ds_sel <= sel.
  - htrans[1]==1 and sel >= NUM_SLAVES -> DP_ERR1.
- When hready == 0, dp_state and ds_sel hold. The exception is DP_ERR1, which moves to DP_ERR2 unconditionally on the next edge.
- DP_ERR2 has hready=1, so it samples the next address phase by the rule above. Back-to-back unmapped transfers give the sequence ERR1, ERR2, ERR1, ERR2, ...
- Slave wait states: while in DP_SLAVE with hreadyout_s[ds_sel]=0, ds_sel is held. Changes on sel/htrans during the stall are ignored.
- Slave ERROR responses pass through unchanged, including the hready=0 first cycle.
- err_count increments by 1 on every rising edge where hready==1 and hresp==1, i.e. on each completed ERROR from either a slave or the default slave. It saturates at all-ones and never wraps.
- Reset (async, hreset=1): dp_state=DP_IDLE, ds_sel=0, err_count=0. Outputs immediately become hrdata=0, hready=1, hresp=0. Reset mid-stall or mid-ERR1 aborts the response with no completion counted.
- With NUM_SLAVES == 2**SEL_WIDTH, DP_ERR1 is unreachable; the logic must still synthesise.
- Parameter violation (NUM_SLAVES > 2**SEL_WIDTH or NUM_SLAVES < 1) is flagged by a simulation-time $error.

Test Plan:
- Reset then IDLE: hreset pulse, htrans=00 for 3 cycles -> hrdata=0, hready=1, hresp=0, err_count=0 throughout.
- Pipelined reads: NONSEQ to sel=1, then sel=2, with hrdata_s slave1=32'hAAAA_0001, slave2=32'hBBBB_0002, all hreadyout=1. The mux must not follow sel combinationally during the address phase.
  - hrdata=32'hAAAA_0001 in the cycle after the sel=1 address phase.
  - hrdata=32'hBBBB_0002 the following cycle.
- Wait state: NONSEQ sel=3, hreadyout_s[3]=0 for 2 cycles, sel changed to 0 during the stall -> hready=0 for 2 cycles, and output stays on slave 3 until hreadyout_s[3]=1.
- Unmapped select: NONSEQ sel=5 (NUM_SLAVES=4) -> cycle1 hready=0/hresp=1, cycle2 hready=1/hresp=1, err_count=1. A following IDLE -> OKAY.
- Slave error plus saturation:
  - Slave 0 returns a 2-cycle ERROR -> err_count increments once.
  - With ERRCNT_WIDTH=2, 5 errors -> err_count=3.
- Async reset asserted during DP_ERR1 -> hready=1, hresp=0 immediately, err_count=0, state DP_IDLE after release.
